wb_led_key: RTL and testbench
=============================

WB_LED_KEY -- requirements
Module: wb_led_key

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 240000, meaning the consecutive stable-sample count (10 ms at 24 MHz wb_clk) required to accept a key level change.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 18, meaning the debounce counter width, with DEBOUNCE_CYCLES <= 2^CNT_WIDTH-1.
REQ-003 The block SHALL have parameter KEY_ACTIVE_LOW, default 1, meaning the raw key pad reads 0 when pressed.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port wb_clk_i, input, 1, the Wishbone/system clock.
REQ-006 The block SHALL have port wb_rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have Wishbone slave ports wb_adr_i in 4 ([3:2] decoded), wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1, wb_dat_o out 32, wb_ack_o out 1, wb_err_o out 1 (tied 0).
REQ-008 The block SHALL have port key_pad_i, input, 1, raw asynchronous push-button pad.
REQ-009 The block SHALL have port led_o, output, 8, board LED drive (1 = lit).
REQ-010 The block SHALL have port irq_o, output, 1, level interrupt to the CPU.

Function
REQ-011 Register map (byte offset): 0x0 LED (RW, [7:0]); 0x4 STATUS (RO, bit0 = debounced pressed level); 0x8 EVENT (W1C, bit0 press, bit1 release); 0xC CTRL (RW, bit0 press-irq enable, bit1 release-irq enable); unused bits read 0.
REQ-012 Handshake: wb_ack_o SHALL assert the cycle after wb_cyc_i & wb_stb_i with wb_ack_o low, stay high exactly one cycle, then drop even if stb is held; a back-to-back access therefore completes every second cycle.
REQ-013 Write takes effect on the cycle wb_ack_o is high; only wb_sel_i[0] gates writes to LED, EVENT and CTRL; writes with wb_sel_i[0]=0 and writes to STATUS SHALL be ignored but still acked.
REQ-014 wb_dat_o SHALL be valid while wb_ack_o is high, reflecting register values at the access start cycle.
REQ-015 key_pad_i SHALL pass through a two-flop synchronizer; sample = synchronized value XOR KEY_ACTIVE_LOW gives pressed=1.
REQ-016 Debouncer: counter clears whenever sample equals the debounced level; otherwise increments by 1 per cycle; when counter reaches DEBOUNCE_CYCLES-1 while sample still differs, debounced level SHALL toggle on the next edge and counter clear.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave debounced level unchanged; counter never wraps.
REQ-018 Rising debounced transition SHALL set EVENT bit0; falling SHALL set EVENT bit1, in the same cycle the level updates.
REQ-019 EVENT bits are sticky until cleared by writing 1; hardware set and software clear in the same cycle SHALL leave the bit set.
REQ-020 irq_o SHALL equal |(EVENT[1:0] & CTRL[1:0]), combinational from registered state only.
REQ-021 led_o SHALL equal LED register directly.

Reset
REQ-022 On wb_rst_i high at a clock edge: LED=0x00, CTRL=0, EVENT=0, debounced level=0 (released), counter=0, synchronizer flops = released level, wb_ack_o=0, hence led_o=0x00 and irq_o=0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no ack and no register write; the cycle after reset drops, a held cyc&stb SHALL be acked normally.
REQ-024 Reset asserted mid-debounce SHALL discard the count; no event results from a transition in progress.

Verification (DEBOUNCE_CYCLES=16 for sim)
REQ-025 Write 0x000000A5 to 0x0, sel=0xF -> ack one cycle later, led_o=0xA5; read 0x0 -> 0x000000A5.
REQ-026 Hold stb 4 cycles on read of 0x4 -> ack pattern 0,1,0,1; write to 0x4 ignored, read stays 0.
REQ-027 Drive key_pad_i low (pressed) for 10 cycles then high -> STATUS bit0 stays 0, EVENT=0, irq_o=0.
REQ-028 CTRL=0x1, drive key_pad_i low 40 cycles -> STATUS bit0=1 at 2+16 cycles after synchronized change, EVENT=0x1, irq_o=1; write 0x1 to 0x8 -> EVENT=0, irq_o=0.
REQ-029 Release debounce completes in the same cycle a W1C of 0x2 lands -> EVENT bit1 remains 1.
REQ-030 Assert wb_rst_i during an ack cycle with LED=0x3C and EVENT=0x3 -> next cycle led_o=0x00, irq_o=0, wb_ack_o=0.

Source files
------------

// File: rtl/wb_led_key.sv
// Wishbone slave with an 8-bit LED register and one debounced push-button key.
// Ack comes one cycle after cyc&stb; the key level settles 2 + DEBOUNCE_CYCLES cycles after a pad change.
// No backpressure: every access is acked, and back-to-back accesses complete every second cycle.
module wb_led_key #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int CNT_WIDTH       = 18,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   input  logic        key_pad_i,
   output logic [7:0]  led_o,
   output logic        irq_o
);

   // Register offsets, decoded from wb_adr_i[3:2].
   localparam logic [1:0] ADR_LED    = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_EVENT  = 2'd2;
   localparam logic [1:0] ADR_CTRL   = 2'd3;

   // Counter value at which a still-differing sample flips the debounced level.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                 ack_q,    ack_d;
   logic [31:0]          rdata_q,  rdata_d;
   logic [7:0]           led_q,    led_d;
   logic [1:0]           ctrl_q,   ctrl_d;
   logic [1:0]           event_q,  event_d;
   logic                 sync1_q,  sync2_q;
   logic                 level_q,  level_d;
   logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic       req;
   logic       start;
   logic       wr_en;
   logic [1:0] reg_sel;
   logic       sample;
   logic       rise;
   logic       fall;
   logic [1:0] ev_clr;

   assign req     = wb_cyc_i & wb_stb_i;
   // A new access begins only when no ack is outstanding, so a held strobe
   // produces an ack every second cycle.
   assign start   = req & ~ack_q;
   // Writes commit at the end of the ack cycle; only byte lane 0 carries data.
   assign wr_en   = ack_q & req & wb_we_i & wb_sel_i[0];
   assign reg_sel = wb_adr_i[3:2];

   // Bits that carry no information for this slave.
   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

   // ------------------------------------------------------------------
   // Key path
   // ------------------------------------------------------------------
   // Two-flop synchronizer on the asynchronous pad; reset loads the released pad level.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q <= KEY_ACTIVE_LOW;
         sync2_q <= KEY_ACTIVE_LOW;
      end else begin
         sync1_q <= key_pad_i;
         sync2_q <= sync1_q;
      end
   end

   // Normalise the pad so that 1 always means pressed.
   assign sample = sync2_q ^ KEY_ACTIVE_LOW;

   // Debounce: count consecutive differing samples and flip the level once
   // DEBOUNCE_CYCLES of them have been seen; any agreeing sample restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sample == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = ~level_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

   // Debounced level and its stability counter.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   // Next-state for LED, CTRL and the sticky EVENT bits; a hardware set wins
   // over a write-one-to-clear landing in the same cycle.
   always_comb begin
      led_d  = led_q;
      ctrl_d = ctrl_q;
      ev_clr = 2'b00;
      if (wr_en) begin
         case (reg_sel)
            ADR_LED:   led_d  = wb_dat_i[7:0];
            ADR_EVENT: ev_clr = wb_dat_i[1:0];
            ADR_CTRL:  ctrl_d = wb_dat_i[1:0];
            default:   ;
         endcase
      end
      event_d = (event_q & ~ev_clr) | {fall, rise};
   end

   // Software-visible registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         led_q   <= 8'h00;
         ctrl_q  <= 2'b00;
         event_q <= 2'b00;
      end else begin
         led_q   <= led_d;
         ctrl_q  <= ctrl_d;
         event_q <= event_d;
      end
   end

   // ------------------------------------------------------------------
   // Handshake and read data
   // ------------------------------------------------------------------
   // Read data is snapshotted on the start cycle so it reflects the registers
   // as they were when the access began.
   always_comb begin
      ack_d   = start;
      rdata_d = rdata_q;
      if (start) begin
         case (reg_sel)
            ADR_LED:    rdata_d = {24'h0, led_q};
            ADR_STATUS: rdata_d = {31'h0, level_q};
            ADR_EVENT:  rdata_d = {30'h0, event_q};
            ADR_CTRL:   rdata_d = {30'h0, ctrl_q};
            default:    rdata_d = 32'h0;
         endcase
      end
   end

   // Ack pulse and read-data register; reset drops any access in flight.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign wb_dat_o = rdata_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = 1'b0;
   assign led_o    = led_q;
   assign irq_o    = |(event_q & ctrl_q);

endmodule

// File: tb/tb_wb_led_key.sv
// Bench for wb_led_key: directed scenarios plus randomized register traffic
// checked against a register-level model (LED, CTRL, sticky EVENT, key level).
// Key timing is modelled as "a pad change held long enough is seen 2 + DEB cycles later".
module tb_wb_led_key;
   localparam int DEB = 16;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [3:0]  wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        key_pad_i = 1'b1;
   logic [7:0]  led_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [7:0] m_led   = 8'h00;
   logic [1:0] m_ctrl  = 2'b00;
   logic [1:0] m_event = 2'b00;
   logic       m_level = 1'b0;

   always #5 clk = ~clk;

   wb_led_key #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_WIDTH(18),
      .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (wb_rst_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .key_pad_i(key_pad_i),
      .led_o    (led_o),
      .irq_o    (irq_o)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One Wishbone access; returns read data and ack latency (-1 if no ack).
   task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int lat);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      lat = -1;
      rd  = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (wb_ack_o) begin
            lat = i;
            rd  = wb_dat_o;
            break;
         end
      end
      tick();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int lat;
      wb_rst_i = 1'b1;
      tick(3);
      checks++;
      if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led got %h expected 00", led_o); end
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq_o); end
      checks++;
      if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", wb_ack_o); end
      checks++;
      if (wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", wb_err_o); end
      wb_rst_i = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) begin
         bus(1'b0, 4'(a * 4), 32'h0, 4'hF, rd, lat);
         checks++;
         if (rd !== 32'h0 || lat != 1) begin
            errors++;
            $display("FAIL reset_reg%0d got %h lat %0d expected 00000000 lat 1", a, rd, lat);
         end
      end
   endtask

   task automatic test_led_rw();
      logic [31:0] rd;
      int lat;
      bus(1'b1, 4'h0, 32'h0000_00A5, 4'hF, rd, lat);
      m_led = 8'hA5;
      checks++;
      if (lat != 1) begin errors++; $display("FAIL led_wr_lat got %0d expected 1", lat); end
      checks++;
      if (led_o !== m_led) begin errors++; $display("FAIL led_out got %h expected %h", led_o, m_led); end
      bus(1'b0, 4'h0, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== {24'h0, m_led}) begin errors++; $display("FAIL led_rd got %h expected %h", rd, {24'h0, m_led}); end
      // Byte lane 0 disabled: write ignored.
      bus(1'b1, 4'h0, 32'h0000_005A, 4'hE, rd, lat);
      checks++;
      if (led_o !== m_led || lat != 1) begin
         errors++;
         $display("FAIL led_sel0_off got %h lat %0d expected %h lat 1", led_o, lat, m_led);
      end
      // Only lane 0 enabled: upper data ignored.
      bus(1'b1, 4'h0, 32'hFFFF_FF3C, 4'h1, rd, lat);
      m_led = 8'h3C;
      bus(1'b0, 4'h0, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h0000_003C) begin errors++; $display("FAIL led_sel0_only got %h expected 0000003c", rd); end
   endtask

   task automatic test_ack_pattern();
      logic [31:0] rd;
      logic [3:0] pat;
      int lat;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 4'h4;
      wb_sel_i = 4'hF;
      pat[0] = wb_ack_o;
      for (int i = 1; i < 4; i++) begin
         tick();
         pat[i] = wb_ack_o;
      end
      tick();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      checks++;
      if (pat !== 4'b1010) begin errors++; $display("FAIL ack_pattern got %b expected 1010 (msb=last)", pat); end
      bus(1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, rd, lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL status_wr_ack got %0d expected 1", lat); end
      bus(1'b0, 4'h4, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL status_ro got %h expected 00000000", rd); end
      bus(1'b0, 4'h0, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== {24'h0, m_led}) begin errors++; $display("FAIL status_wr_side got %h expected %h", rd, {24'h0, m_led}); end
   endtask

   task automatic test_glitch();
      logic [31:0] rd;
      int lat;
      int lens[2] = '{10, DEB - 1};
      logic saw_irq;
      bus(1'b1, 4'hC, 32'h3, 4'hF, rd, lat);
      m_ctrl = 2'b11;
      foreach (lens[j]) begin
         saw_irq = 1'b0;
         key_pad_i = 1'b0;
         for (int i = 0; i < lens[j]; i++) begin tick(); saw_irq |= irq_o; end
         key_pad_i = 1'b1;
         for (int i = 0; i < DEB + 10; i++) begin tick(); saw_irq |= irq_o; end
         checks++;
         if (saw_irq !== 1'b0) begin errors++; $display("FAIL glitch%0d_irq got 1 expected 0", lens[j]); end
         bus(1'b0, 4'h4, 32'h0, 4'hF, rd, lat);
         checks++;
         if (rd !== {31'h0, m_level}) begin errors++; $display("FAIL glitch%0d_status got %h expected %h", lens[j], rd, {31'h0, m_level}); end
         bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
         checks++;
         if (rd !== {30'h0, m_event}) begin errors++; $display("FAIL glitch%0d_event got %h expected %h", lens[j], rd, {30'h0, m_event}); end
      end
   endtask

   task automatic test_press_irq();
      logic [31:0] rd;
      int lat;
      int first;
      bus(1'b1, 4'hC, 32'h1, 4'hF, rd, lat);
      m_ctrl = 2'b01;
      key_pad_i = 1'b0;
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (irq_o === 1'b1 && first < 0) first = k;
      end
      m_level = 1'b1;
      m_event = 2'b01;
      checks++;
      if (first != 2 + DEB) begin errors++; $display("FAIL press_latency got %0d expected %0d", first, 2 + DEB); end
      bus(1'b0, 4'h4, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL press_status got %h expected 00000001", rd); end
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL press_event got %h expected 00000001", rd); end
      bus(1'b1, 4'h8, 32'h1, 4'hF, rd, lat);
      m_event = 2'b00;
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL press_w1c got event %h irq %b expected 00000000 irq 0", rd, irq_o);
      end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] rd;
      int lat;
      bus(1'b1, 4'hC, 32'h2, 4'hF, rd, lat);
      m_ctrl = 2'b10;
      key_pad_i = 1'b1;
      // Start the W1C so its ack cycle ends on the edge where the release is accepted.
      tick(DEB);
      bus(1'b1, 4'h8, 32'h2, 4'hF, rd, lat);
      m_level = 1'b0;
      m_event = 2'b10;
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== {30'h0, m_event}) begin errors++; $display("FAIL collide_event got %h expected %h", rd, {30'h0, m_event}); end
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL collide_irq got %b expected 1", irq_o); end
      bus(1'b0, 4'h4, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL collide_status got %h expected 00000000", rd); end
      bus(1'b1, 4'h8, 32'h2, 4'hF, rd, lat);
      m_event = 2'b00;
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL collide_reclear got %h expected 00000000", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, dat, exp;
      logic [3:0] adr, sel;
      logic we;
      int lat;
      for (int n = 0; n < 150; n++) begin
         // Occasionally toggle the key long enough to be accepted.
         if (n % 25 == 0) begin
            key_pad_i = m_level;
            tick(2 + DEB + 6);
            m_level = ~m_level;
            m_event = m_event | (m_level ? 2'b01 : 2'b10);
         end
         adr = 4'($urandom_range(0, 3) * 4);
         dat = $urandom;
         sel = 4'($urandom_range(0, 15));
         we  = 1'($urandom_range(0, 1));
         case (adr)
            4'h0:    exp = {24'h0, m_led};
            4'h4:    exp = {31'h0, m_level};
            4'h8:    exp = {30'h0, m_event};
            default: exp = {30'h0, m_ctrl};
         endcase
         bus(we, adr, dat, sel, rd, lat);
         if (we && sel[0]) begin
            if (adr == 4'h0) m_led = dat[7:0];
            if (adr == 4'h8) m_event = m_event & ~dat[1:0];
            if (adr == 4'hC) m_ctrl = dat[1:0];
         end
         checks++;
         if (lat != 1) begin errors++; $display("FAIL rnd%0d_lat got %0d expected 1", n, lat); end
         if (!we) begin
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL rnd%0d_rd adr %h got %h expected %h", n, adr, rd, exp); end
         end
         checks++;
         if (led_o !== m_led || irq_o !== |(m_event & m_ctrl)) begin
            errors++;
            $display("FAIL rnd%0d_out got led %h irq %b expected led %h irq %b",
                     n, led_o, irq_o, m_led, |(m_event & m_ctrl));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lat;
      bus(1'b1, 4'h0, 32'h3C, 4'hF, rd, lat);
      bus(1'b1, 4'hC, 32'h3, 4'hF, rd, lat);
      // Make sure both events are pending: a full press then a full release.
      if (m_level == 1'b1) begin key_pad_i = 1'b1; tick(2 + DEB + 4); end
      key_pad_i = 1'b0; tick(2 + DEB + 4);
      key_pad_i = 1'b1; tick(2 + DEB + 4);
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h3 || irq_o !== 1'b1 || led_o !== 8'h3C) begin
         errors++;
         $display("FAIL rstmid_pre got event %h irq %b led %h expected 00000003 1 3c", rd, irq_o, led_o);
      end
      // A press is mid-debounce when reset hits the ack cycle of a write.
      key_pad_i = 1'b0;
      tick(8);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 4'h0; wb_dat_i = 32'hFF; wb_sel_i = 4'hF;
      tick();
      checks++;
      if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL rstmid_ack_pre got %b expected 1", wb_ack_o); end
      wb_rst_i = 1'b1;
      key_pad_i = 1'b1;
      tick();
      checks++;
      if (led_o !== 8'h00 || irq_o !== 1'b0 || wb_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_abort got led %h irq %b ack %b expected 00 0 0", led_o, irq_o, wb_ack_o);
      end
      wb_rst_i = 1'b0;
      tick();
      checks++;
      if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL rstmid_reack got %b expected 1", wb_ack_o); end
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      checks++;
      if (led_o !== 8'hFF) begin errors++; $display("FAIL rstmid_write got %h expected ff", led_o); end
      tick(2 + DEB + 10);
      bus(1'b0, 4'h8, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_event got %h expected 00000000", rd); end
      bus(1'b0, 4'h4, 32'h0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_status got %h expected 00000000", rd); end
   endtask

   initial begin
      test_reset();
      test_led_rw();
      test_ack_pattern();
      test_glitch();
      test_press_irq();
      test_w1c_collision();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

endmodule
